k_sorting_p2_merge: RTL and testbench

//  Phase-2 reader for two phase-1 sorters: list A holds even entry IDs, list B

---
 rtl/k_sorting_p2_merge.sv | 173 +++++++++++++++++
 tb/tb_k_sorting_p2_merge.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k_sorting_p2_merge.sv
// k_sorting_p2_merge: phase-2 reader for a pair of phase-1 sorters.
// List A holds even entry IDs and list B holds odd entry IDs. Each list holds K
// entries in ascending distance order. This block reads the two list heads,
// merges them with ties going to A, and streams the global K nearest entries
// over a valid/ready interface. A result can be loaded every cycle.
// Optional feature: define KSORT_P2_STATS_EN to add the a_taken_o/b_taken_o
// per-list consumption counters.
module k_sorting_p2_merge #(
   parameter int unsigned K          = 1,
   parameter int unsigned VAL_WIDTH  = 32,
   parameter int unsigned NAME_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   output logic                  p1_done_o,
   output logic                  a_out_en_o,
   output logic                  b_out_en_o,
   input  logic [NAME_WIDTH-1:0] a_name_i,
   input  logic [VAL_WIDTH-1:0]  a_value_i,
   input  logic [NAME_WIDTH-1:0] b_name_i,
   input  logic [VAL_WIDTH-1:0]  b_value_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [NAME_WIDTH-1:0] m_name_o,
   output logic [VAL_WIDTH-1:0]  m_value_o,
   output logic                  m_last_o,
   output logic                  busy_o,
   output logic                  finished_o
`ifdef KSORT_P2_STATS_EN
   ,
   output logic [$clog2(K+1)-1:0] a_taken_o,
   output logic [$clog2(K+1)-1:0] b_taken_o
`endif
);

   localparam int unsigned CW = $clog2(K + 1);
   localparam logic [CW-1:0] KCnt  = CW'(K);
   localparam logic [CW-1:0] KLast = CW'(K - 1);
   localparam logic [CW-1:0] One   = CW'(1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StMerge = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_a_q, cnt_a_d;
   logic [CW-1:0]         cnt_b_q, cnt_b_d;
   logic [CW-1:0]         cnt_out_q, cnt_out_d;
   logic                  m_valid_q, m_valid_d;
   logic [NAME_WIDTH-1:0] m_name_q, m_name_d;
   logic [VAL_WIDTH-1:0]  m_value_q, m_value_d;
   logic                  m_last_q, m_last_d;

   logic load;
   logic sel_a;
   logic a_avail;

   // Load/selection decision: one result per cycle while merging and the output slot is free.
   // Reset gates the load so no sorter pointer advances during a reset cycle.
   always_comb begin
      a_avail = (cnt_a_q != KCnt);
      sel_a   = (cnt_b_q == KCnt) || (a_avail && (a_value_i <= b_value_i));
      load    = (state_q == StMerge) && (!m_valid_q || m_ready_i) && !reset;
   end

   // Next-state logic for the merge controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StMerge;
            end
         end
         StMerge: begin
            if (load && (cnt_out_q == KLast)) begin
               state_d = StDone;
            end
         end
         // Pointers are saturated; only a system reset leaves this state.
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output register and list counters: capture the selected head on a load.
   always_comb begin
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      cnt_out_d = cnt_out_q;
      m_valid_d = m_valid_q;
      m_name_d  = m_name_q;
      m_value_d = m_value_q;
      m_last_d  = m_last_q;
      if (load) begin
         m_valid_d = 1'b1;
         m_last_d  = (cnt_out_q == KLast);
         cnt_out_d = cnt_out_q + One;
         if (sel_a) begin
            m_name_d  = a_name_i;
            m_value_d = a_value_i;
            cnt_a_d   = cnt_a_q + One;
         end else begin
            m_name_d  = b_name_i;
            m_value_d = b_value_i;
            cnt_b_d   = cnt_b_q + One;
         end
      end else if (m_ready_i) begin
         // Beat accepted with nothing new behind it.
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
         cnt_out_q <= '0;
         m_valid_q <= 1'b0;
         m_name_q  <= '0;
         m_value_q <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
         cnt_out_q <= cnt_out_d;
         m_valid_q <= m_valid_d;
         m_name_q  <= m_name_d;
         m_value_q <= m_value_d;
         m_last_q  <= m_last_d;
      end
   end

   // Output drive: sorter handshakes are combinational so the pointer moves on the load edge.
   always_comb begin
      p1_done_o  = (state_q != StIdle);
      a_out_en_o = load && sel_a;
      b_out_en_o = load && !sel_a;
      m_valid_o  = m_valid_q;
      m_name_o   = m_name_q;
      m_value_o  = m_value_q;
      m_last_o   = m_last_q;
      busy_o     = (state_q == StMerge) || m_valid_q;
      finished_o = (state_q == StDone) && !m_valid_q;
   end

`ifdef KSORT_P2_STATS_EN
   // Consumption counters; they stop moving once no more loads occur.
   always_comb begin
      a_taken_o = cnt_a_q;
      b_taken_o = cnt_b_q;
   end
`endif

   // The two read pointers never advance together.
   assert property (@(posedge clk) disable iff (reset) !(a_out_en_o && b_out_en_o));

   // An exhausted list is never read again.
   assert property (@(posedge clk) disable iff (reset)
                    !(a_out_en_o && (cnt_a_q == KCnt)) && !(b_out_en_o && (cnt_b_q == KCnt)));

endmodule

// File: tb/tb_k_sorting_p2_merge.sv
// Bench for k_sorting_p2_merge: a K=4 instance checked every cycle against a
// sort-based model, and a K=3 instance checked with hand-computed expectations.
module tb_k_sorting_p2_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        p1_done, a_oe, b_oe, m_valid, m_ready, m_last, busy, finished;
   logic [31:0] a_name, a_value, b_name, b_value, m_name, m_value;
`ifdef KSORT_P2_STATS_EN
   logic [2:0]  a_taken, b_taken;
`endif

   logic        start2;
   logic        p1_done2, a_oe2, b_oe2, m_valid2, m_last2, busy2, finished2;
   logic        m_ready2;
   logic [31:0] a_name2, a_value2, b_name2, b_value2, m_name2, m_value2;
`ifdef KSORT_P2_STATS_EN
   logic [1:0]  a_taken2, b_taken2;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   k_sorting_p2_merge #(.K(4), .VAL_WIDTH(32), .NAME_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_i(start), .p1_done_o(p1_done),
      .a_out_en_o(a_oe), .b_out_en_o(b_oe),
      .a_name_i(a_name), .a_value_i(a_value), .b_name_i(b_name), .b_value_i(b_value),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_name_o(m_name), .m_value_o(m_value),
      .m_last_o(m_last), .busy_o(busy), .finished_o(finished)
`ifdef KSORT_P2_STATS_EN
      , .a_taken_o(a_taken), .b_taken_o(b_taken)
`endif
   );

   k_sorting_p2_merge #(.K(3), .VAL_WIDTH(32), .NAME_WIDTH(32)) dut3 (
      .clk(clk), .reset(reset), .start_i(start2), .p1_done_o(p1_done2),
      .a_out_en_o(a_oe2), .b_out_en_o(b_oe2),
      .a_name_i(a_name2), .a_value_i(a_value2), .b_name_i(b_name2), .b_value_i(b_value2),
      .m_valid_o(m_valid2), .m_ready_i(m_ready2), .m_name_o(m_name2), .m_value_o(m_value2),
      .m_last_o(m_last2), .busy_o(busy2), .finished_o(finished2)
`ifdef KSORT_P2_STATS_EN
      , .a_taken_o(a_taken2), .b_taken_o(b_taken2)
`endif
   );

   // Sorter models: list contents plus a read pointer advanced by out_en.
   logic [31:0] a_val [4];
   logic [31:0] a_nm  [4];
   logic [31:0] b_val [4];
   logic [31:0] b_nm  [4];
   int pa = 0, pb = 0;
   logic [31:0] a_val2 [3];
   logic [31:0] a_nm2  [3];
   logic [31:0] b_val2 [3];
   logic [31:0] b_nm2  [3];
   int pa2 = 0, pb2 = 0;

   always @(posedge clk) begin
      if (reset) begin
         pa <= 0; pb <= 0; pa2 <= 0; pb2 <= 0;
      end else begin
         if (a_oe && pa < 4) pa <= pa + 1;
         if (b_oe && pb < 4) pb <= pb + 1;
         if (a_oe2 && pa2 < 3) pa2 <= pa2 + 1;
         if (b_oe2 && pb2 < 3) pb2 <= pb2 + 1;
      end
   end

   assign a_value  = (pa < 4) ? a_val[pa] : 32'hFFFF_FFFF;
   assign a_name   = (pa < 4) ? a_nm[pa]  : 32'hFFFF_FFFF;
   assign b_value  = (pb < 4) ? b_val[pb] : 32'hFFFF_FFFF;
   assign b_name   = (pb < 4) ? b_nm[pb]  : 32'hFFFF_FFFF;
   assign a_value2 = (pa2 < 3) ? a_val2[pa2] : 32'hFFFF_FFFF;
   assign a_name2  = (pa2 < 3) ? a_nm2[pa2]  : 32'hFFFF_FFFF;
   assign b_value2 = (pb2 < 3) ? b_val2[pb2] : 32'hFFFF_FFFF;
   assign b_name2  = (pb2 < 3) ? b_nm2[pb2]  : 32'hFFFF_FFFF;

   // Model: the expected K results and which list each one comes from.
   logic [31:0] exp_val [4];
   logic [31:0] exp_nm  [4];
   int          exp_src [4];   // 0 = list A, 1 = list B
   int acc_idx = 0;
   int load_idx = 0;
   int b_oe_cnt = 0;
   int first_acc_cyc = -1;
   int last_acc_cyc = -1;
   bit          have_prev = 0;
   logic [64:0] prev_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, want);
      end
   endtask

   // Global order is a stable sort of all 8 entries by (value, list, position):
   // equal values drain A before B, and each list keeps its own order.
   task automatic compute_model();
      logic [31:0] kv [8];
      logic [31:0] kn [8];
      int kl [8];
      int ki [8];
      logic [31:0] tv, tn;
      int tl, ti;
      for (int i = 0; i < 4; i++) begin
         kv[i] = a_val[i]; kn[i] = a_nm[i]; kl[i] = 0; ki[i] = i;
         kv[i+4] = b_val[i]; kn[i+4] = b_nm[i]; kl[i+4] = 1; ki[i+4] = i;
      end
      for (int i = 1; i < 8; i++) begin
         for (int j = i; j > 0; j--) begin
            if ((kv[j-1] > kv[j]) ||
                (kv[j-1] == kv[j] && (kl[j-1] > kl[j] || (kl[j-1] == kl[j] && ki[j-1] > ki[j]))))
            begin
               tv = kv[j]; tn = kn[j]; tl = kl[j]; ti = ki[j];
               kv[j] = kv[j-1]; kn[j] = kn[j-1]; kl[j] = kl[j-1]; ki[j] = ki[j-1];
               kv[j-1] = tv; kn[j-1] = tn; kl[j-1] = tl; ki[j-1] = ti;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         exp_val[i] = kv[i]; exp_nm[i] = kn[i]; exp_src[i] = kl[i];
      end
   endtask

   task automatic set_lists(input int which);
      for (int i = 0; i < 4; i++) begin
         a_nm[i] = 32'(2 * i);
         b_nm[i] = 32'(2 * i + 1);
      end
      if (which == 1) begin
         a_val[0] = 1; a_val[1] = 5; a_val[2] = 9;  a_val[3] = 32'hFFFF_FFFF;
         b_val[0] = 2; b_val[1] = 3; b_val[2] = 10; b_val[3] = 32'hFFFF_FFFF;
         a_nm[3] = 32'hFFFF_FFFF; b_nm[3] = 32'hFFFF_FFFF;
      end else begin
         for (int i = 0; i < 4; i++) begin
            a_val[i] = 7; b_val[i] = 7;
         end
      end
      compute_model();
   endtask

   // Per-cycle compare against the model for the K=4 instance.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            have_prev = 0;
         end else begin
            if (a_oe && b_oe) chk("oe_onehot", 1, 0);
            if ((a_oe || b_oe) && m_valid && !m_ready) chk("oe_while_stalled", 1, 0);
            if (a_oe || b_oe) begin
               if (b_oe) b_oe_cnt++;
               if (load_idx < 4) chk("oe_src", 64'(b_oe), 64'(exp_src[load_idx]));
               else chk("oe_extra", 64'(load_idx), 4);
               load_idx++;
            end
            if (have_prev) chk("stall_hold", {m_valid, m_last, m_name, m_value}, {1'b1, prev_out});
            if (m_valid && m_ready) begin
               if (acc_idx < 4) begin
                  chk("res_name", m_name, exp_nm[acc_idx]);
                  chk("res_value", m_value, exp_val[acc_idx]);
                  chk("res_last", 64'(m_last), 64'(acc_idx == 3));
               end else begin
                  chk("extra_result", 64'(acc_idx), 4);
               end
               if (acc_idx == 0) first_acc_cyc = cyc;
               last_acc_cyc = cyc;
               acc_idx++;
            end
            have_prev = m_valid && !m_ready;
            prev_out  = {m_last, m_name, m_value};
         end
      end
   end

   // Backpressure driver: always ready, or toggling every cycle.
   int rdy_mode = 0;
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = (rdy_mode != 0) ? ~m_ready : 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {p1_done, a_oe, b_oe, m_valid, m_last, busy, finished}, 0);
      chk({tag, "_data"}, {m_name, m_value}, 0);
   endtask

   task automatic begin_merge(input int rmode, output int c0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      rdy_mode = rmode;
      acc_idx = 0; load_idx = 0; b_oe_cnt = 0;
      first_acc_cyc = -1; last_acc_cyc = -1;
      start = 1'b1;
      c0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_results(input int n);
      int t;
      t = 0;
      while (acc_idx < n && t < 200) begin
         step();
         t++;
      end
      if (acc_idx < n) chk("timeout", 64'(acc_idx), 64'(n));
   endtask

   task automatic finish_merge();
      wait_results(4);
      @(negedge clk);
      chk("finished", {finished, busy, p1_done}, 3'b101);
      step();
      rdy_mode = 0;
   endtask

   int c0;
   int cnt_a2, cnt_b2, acc2;
   logic [31:0] last_val2;

   initial begin
      reset = 1'b1; start = 1'b0; start2 = 1'b0; m_ready2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_val[i] = '0; a_nm[i] = '0; b_val[i] = '0; b_nm[i] = '0;
      end
      a_val2[0] = 1; a_val2[1] = 2; a_val2[2] = 3;
      b_val2[0] = 8; b_val2[1] = 9; b_val2[2] = 9;
      for (int i = 0; i < 3; i++) begin
         a_nm2[i] = 32'(2 * i); b_nm2[i] = 32'(2 * i + 1);
      end
      step();
      step();
      @(negedge clk);
      check_zero("reset_state");
      step();
      reset = 1'b0;

      // 1: reference merge, no backpressure, plus literal pins on the model.
      set_lists(1);
      chk("pin_vals", {exp_val[0], exp_val[1]}, {32'd1, 32'd2});
      chk("pin_vals2", {exp_val[2], exp_val[3]}, {32'd3, 32'd5});
      chk("pin_names", {exp_nm[0][7:0], exp_nm[1][7:0], exp_nm[2][7:0], exp_nm[3][7:0]},
          32'h00010302);
      chk("pin_src", 64'({exp_src[0][0], exp_src[1][0], exp_src[2][0], exp_src[3][0]}), 4'b0110);
      begin_merge(0, c0);
      finish_merge();
      chk("lat_first", 64'(first_acc_cyc), 64'(c0 + 2));
      chk("lat_last", 64'(last_acc_cyc), 64'(c0 + 5));

      // 2: same lists under toggling backpressure.
      begin_merge(1, c0);
      finish_merge();
      chk("bp_count", 64'(acc_idx), 4);

      // 3: all values equal; A wins every tie.
      set_lists(3);
      chk("pin_tie_names", {exp_nm[0][7:0], exp_nm[1][7:0], exp_nm[2][7:0], exp_nm[3][7:0]},
          32'h00020406);
      begin_merge(0, c0);
      finish_merge();
      chk("tie_b_oe", 64'(b_oe_cnt), 0);
`ifdef KSORT_P2_STATS_EN
      chk("tie_taken", {a_taken, b_taken}, {3'd4, 3'd0});
`endif

      // 5: reset after the second result, then a clean rerun.
      set_lists(1);
      begin_merge(0, c0);
      wait_results(2);
      reset = 1'b1;
      step();
      @(negedge clk);
      check_zero("mid_reset");
      step();
      reset = 1'b0;
      step();
      @(negedge clk);
      check_zero("after_reset");
      begin_merge(0, c0);
      finish_merge();

      // 6: start pulses in MERGE and in DONE are ignored.
      begin_merge(0, c0);
      start = 1'b1;
      step();
      start = 1'b0;
      finish_merge();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("restart_count", 64'(acc_idx), 4);
      chk("restart_done", {finished, m_valid}, 2'b10);
      step();

      // 4: K=3 instance; A fully precedes B.
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      cnt_a2 = 0; cnt_b2 = 0; acc2 = 0; last_val2 = '0;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_oe2) cnt_a2++;
         if (b_oe2) cnt_b2++;
         if (m_valid2 && m_ready2) begin
            acc2++;
            if (m_last2) last_val2 = m_value2;
         end
         step();
      end
      chk("k3_a_oe", 64'(cnt_a2), 3);
      chk("k3_b_oe", 64'(cnt_b2), 0);
      chk("k3_results", 64'(acc2), 3);
      chk("k3_last_val", last_val2, 3);
      @(negedge clk);
      chk("k3_finished", {finished2, busy2}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
